clk_period_monitor: RTL and testbench
=====================================

Name: clk_period_monitor

Overview:
- Consumer-side checker for the slow divided clocks generated in the clk80 domain, e.g. the 2 MHz telemetry clock, or the same clock returned from an external interface.
- Samples a slow clock input and measures its period and high time in clk80 cycles.
- Compares the period against a nominal window and reports lock, period error and stall.
- Sits beside the divider or at the far end of a cable loopback, as a self-test/health monitor.

Parameters:
CNT_W, 8, width of phase/period counters and measurement outputs
NOM_PERIOD, 40, expected period in clk80 cycles
NOM_HIGH, 19, expected high time in clk80 cycles (used only with duty check)
TOL, 2, allowed +/- deviation in clk80 cycles, inclusive
LOCK_CNT, 4, consecutive good periods required to assert locked
TIMEOUT, 200, phase length in cycles that declares a stall (must be < 2^CNT_W)

Ports:
clk80  input  1  system clock, 80.64 MHz
reset  input  1  asynchronous, active-low reset
clk_in  input  1  monitored slow clock, asynchronous to clk80
period_out  output  CNT_W  last measured period, clk80 cycles
high_out  output  CNT_W  last measured high time, clk80 cycles
meas_valid  output  1  one-cycle pulse when period_out/high_out update
locked  output  1  level, LOCK_CNT consecutive in-tolerance periods seen
err_period  output  1  one-cycle pulse, measured period out of tolerance
stalled  output  1  level, no edge for TIMEOUT cycles
err_duty  output  1  one-cycle pulse, high time out of tolerance (see Optional Feature)

Behaviour:
- Reset (async, reset=0): all outputs 0, synchronizer flops 0, counters 0, state IDLE.
- Input path: 2-flop synchronizer, then a third "previous" flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge pulse appears 3 clk80 cycles after the input transition.
  - rise and fall are mutually exclusive by construction.
- State machine:
  - IDLE: wait for rise. On rise: phase_cnt<=1, go HIGH. No measurement is produced.
  - HIGH: phase_cnt increments each cycle. On fall: hi_lat<=phase_cnt, phase_cnt<=1, go LOW.
  - LOW: phase_cnt increments each cycle. On rise:
    - period = hi_lat + phase_cnt, computed CNT_W wide.
    - period_out<=period, high_out<=hi_lat, meas_valid=1 for one cycle.
    - phase_cnt<=1, go HIGH.
- Period check, on each measurement:
  - Good when NOM_PERIOD-TOL <= period <= NOM_PERIOD+TOL.
  - Good: good_cnt increments, saturating at LOCK_CNT. locked<=1 in the same cycle good_cnt reaches LOCK_CNT.
  - Bad: err_period pulses, good_cnt<=0, locked<=0 in the same cycle.
- First measurement:
  - Valid only after one full HIGH+LOW following IDLE.
  - Result: 40-cycle/20-high input gives the first meas_valid at the second observed rise.
- Timeout:
  - Condition: in HIGH or LOW, phase_cnt reaches TIMEOUT.
  - Action: stalled<=1, locked<=0, good_cnt<=0, go IDLE. No err_period pulse.
  - phase_cnt saturates; it never wraps.
  - stalled clears on the next rise (the IDLE->HIGH transition).
- Arithmetic: period sum saturates at 2^CNT_W-1 (only reachable if TIMEOUT is misconfigured).
- Glitches:
  - Any synchronized edge is honoured; no filtering.
  - A 1-cycle glitch yields a short phase and therefore a bad period.
- Reset mid-operation: immediate return to reset values; measurement restarts from IDLE.

Optional Feature:
- Macro: CLK_MON_DUTY_CHECK_EN.
- Defined:
  - At each measurement, high_out is also checked against NOM_HIGH +/- TOL (inclusive).
  - Out of window: err_duty pulses in the meas_valid cycle, good_cnt<=0, locked<=0.
  - A measurement counts as good only if both period and high time are in window.
- Undefined: err_duty tied to 0; high time is measured and reported but not checked.

Test Plan:
- Reset held, clk_in toggling -> all outputs 0. Release -> first meas_valid at second observed rise with period_out=40, high_out=20; locked rises on 4th consecutive meas_valid.
- Locked at period 40, then one period of 45 -> err_period pulse with period_out=45, locked drops that cycle; 4 further 40-cycle periods -> locked reasserts.
- Periods of 38 and 42 (boundaries) -> no err_period; periods of 37 and 43 -> err_period each.
- clk_in held high for 250 cycles while locked -> stalled=1 and locked=0 exactly TIMEOUT cycles after last edge; next rise -> stalled=0, next full period -> meas_valid.
- reset pulsed low mid-LOW phase -> outputs 0 immediately; after release, no meas_valid until IDLE->HIGH->LOW->rise sequence completes.
- With CLK_MON_DUTY_CHECK_EN: period 40 with high 30 -> err_duty pulse, no err_period, locked=0. Without the macro: same stimulus -> err_duty=0, lock unaffected.

Source files
------------

// File: rtl/clk_period_monitor.sv
// Slow-clock health monitor: measures period/high time of clk_in in clk80 cycles, reports lock, period error and stall.
// Optional high-time window check enabled by defining CLK_MON_DUTY_CHECK_EN.
module clk_period_monitor #(
  parameter int CNT_W      = 8,
  parameter int NOM_PERIOD = 40,
  parameter int NOM_HIGH   = 19,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int TIMEOUT    = 200
) (
  input  logic             clk80,
  input  logic             reset,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             stalled,
  output logic             err_duty
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(NOM_PERIOD + TOL);
  localparam logic [CNT_W-1:0]  HIGH_MIN  = CNT_W'(NOM_HIGH - TOL);
  localparam logic [CNT_W-1:0]  HIGH_MAX  = CNT_W'(NOM_HIGH + TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);
  localparam logic [GOOD_W-1:0] LOCK_N    = GOOD_W'(LOCK_CNT);
`ifdef CLK_MON_DUTY_CHECK_EN
  localparam logic DUTY_CHK = 1'b1;
`else
  localparam logic DUTY_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t            r_state;
  logic              r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]  r_phase_cnt;
  logic [CNT_W-1:0]  r_hi_lat;
  logic [GOOD_W-1:0] r_good_cnt;
  logic [CNT_W-1:0]  r_period, r_high;
  logic              r_meas_valid, r_locked, r_err_period, r_stalled, r_err_duty;

  logic              w_rise, w_fall, w_edge;
  logic [CNT_W:0]    w_sum;
  logic [CNT_W-1:0]  w_period, w_phase_inc;
  logic              w_per_ok, w_high_ok, w_duty_bad, w_meas_good;
  logic [GOOD_W-1:0] w_good_inc;

  assign w_rise      = r_sync2 & ~r_prev;
  assign w_fall      = ~r_sync2 & r_prev;
  assign w_edge      = (r_state == S_HIGH) ? w_fall : w_rise;
  assign w_sum       = {1'b0, r_hi_lat} + {1'b0, r_phase_cnt};
  assign w_period    = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
  assign w_phase_inc = (&r_phase_cnt) ? r_phase_cnt : r_phase_cnt + ONE;
  assign w_per_ok    = (w_period >= PER_MIN) && (w_period <= PER_MAX);
  assign w_high_ok   = (r_hi_lat >= HIGH_MIN) && (r_hi_lat <= HIGH_MAX);
  assign w_duty_bad  = DUTY_CHK & ~w_high_ok;
  assign w_meas_good = w_per_ok & ~w_duty_bad;
  assign w_good_inc  = (r_good_cnt == LOCK_N) ? LOCK_N : r_good_cnt + 1'b1;

  always_ff @(posedge clk80 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_prev       <= 1'b0;
      r_phase_cnt  <= '0;
      r_hi_lat     <= '0;
      r_good_cnt   <= '0;
      r_period     <= '0;
      r_high       <= '0;
      r_meas_valid <= 1'b0;
      r_locked     <= 1'b0;
      r_err_period <= 1'b0;
      r_stalled    <= 1'b0;
      r_err_duty   <= 1'b0;
    end else begin
      r_sync1      <= clk_in;
      r_sync2      <= r_sync1;
      r_prev       <= r_sync2;
      r_meas_valid <= 1'b0;
      r_err_period <= 1'b0;
      r_err_duty   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_phase_cnt <= ONE;
            r_stalled   <= 1'b0;
            r_state     <= S_HIGH;
          end
        end
        S_HIGH, S_LOW: begin
          // An edge arriving in the timeout cycle still wins over the stall.
          if (w_edge && r_state == S_HIGH) begin
            r_hi_lat    <= r_phase_cnt;
            r_phase_cnt <= ONE;
            r_state     <= S_LOW;
          end else if (w_edge) begin
            r_period     <= w_period;
            r_high       <= r_hi_lat;
            r_meas_valid <= 1'b1;
            r_err_period <= ~w_per_ok;
            r_err_duty   <= w_duty_bad;
            r_phase_cnt  <= ONE;
            r_state      <= S_HIGH;
            if (w_meas_good) begin
              r_good_cnt <= w_good_inc;
              r_locked   <= (w_good_inc == LOCK_N);
            end else begin
              r_good_cnt <= '0;
              r_locked   <= 1'b0;
            end
          end else if (r_phase_cnt >= TIMEOUT_C) begin
            r_stalled  <= 1'b1;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_phase_cnt <= w_phase_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign period_out = r_period;
  assign high_out   = r_high;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;
  assign err_period = r_err_period;
  assign stalled    = r_stalled;
  assign err_duty   = r_err_duty;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor: table of clk_in periods with hand-computed results,
// plus sequences for reset, stall/timeout and reset mid-LOW. Honours CLK_MON_DUTY_CHECK_EN.
module tb_clk_period_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;
`ifdef CLK_MON_DUTY_CHECK_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif

  logic             clk80 = 1'b0;
  logic             reset = 1'b0;
  logic             clk_in = 1'b0;
  logic [CNT_W-1:0] period_out, high_out;
  logic             meas_valid, locked, err_period, stalled, err_duty;

  clk_period_monitor #(
    .CNT_W(CNT_W), .NOM_PERIOD(40), .NOM_HIGH(19), .TOL(2), .LOCK_CNT(4), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk80(clk80), .reset(reset), .clk_in(clk_in),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .locked(locked), .err_period(err_period), .stalled(stalled), .err_duty(err_duty)
  );

  always #5 clk80 = ~clk80;

  typedef struct {
    int hi; int lo; int meas; int period; int high; int err; int duty; int lock;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  int n_cmp = 0, n_bad = 0;
  int n_meas = 0, n_err = 0, n_duty = 0;
  int last_per = 0, last_high = 0;
  int b_meas, b_err, b_duty;

  always @(negedge clk80) begin
    if (meas_valid) begin
      n_meas    <= n_meas + 1;
      last_per  <= int'(period_out);
      last_high <= int'(high_out);
    end
    if (err_period) n_err  <= n_err + 1;
    if (err_duty)   n_duty <= n_duty + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic mark();
    b_meas = n_meas; b_err = n_err; b_duty = n_duty;
  endtask

  task automatic hold(input logic v, input int n);
    clk_in = v;
    repeat (n) @(posedge clk80);
    #1;
  endtask

  task automatic setv(input int i, input int hi, input int lo, input int m, input int p,
                      input int h, input int e, input int d, input int l);
    tbl[i] = '{hi, lo, m, p, h, e, d, l};
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_period"}, int'(period_out), 0);
    chk({name, "_high"}, int'(high_out), 0);
    chk({name, "_flags"}, int'({meas_valid, locked, err_period, stalled, err_duty}), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //       i   hi  lo  meas per high err duty lock
    setv( 0, 20, 20, 0,  0,  0, 0, 0, 0);
    setv( 1, 20, 20, 1, 40, 20, 0, 0, 0);
    setv( 2, 20, 20, 1, 40, 20, 0, 0, 0);
    setv( 3, 20, 20, 1, 40, 20, 0, 0, 0);
    setv( 4, 20, 20, 1, 40, 20, 0, 0, 1);
    setv( 5, 20, 25, 1, 40, 20, 0, 0, 1);
    setv( 6, 20, 20, 1, 45, 20, 1, 0, 0);
    setv( 7, 20, 20, 1, 40, 20, 0, 0, 0);
    setv( 8, 20, 20, 1, 40, 20, 0, 0, 0);
    setv( 9, 20, 20, 1, 40, 20, 0, 0, 0);
    setv(10, 20, 20, 1, 40, 20, 0, 0, 1);
    setv(11, 19, 19, 1, 40, 20, 0, 0, 1);
    setv(12, 21, 21, 1, 38, 19, 0, 0, 1);
    setv(13, 18, 19, 1, 42, 21, 0, 0, 1);
    setv(14, 22, 21, 1, 37, 18, 1, 0, 0);
    setv(15, 20, 20, 1, 43, 22, 1, D, 0);
    setv(16, 20, 20, 1, 40, 20, 0, 0, 0);
    setv(17, 20, 20, 1, 40, 20, 0, 0, 0);
    setv(18, 20, 20, 1, 40, 20, 0, 0, 0);
    setv(19, 20, 20, 1, 40, 20, 0, 0, 1);
    setv(20, 30, 10, 1, 40, 20, 0, 0, 1);
    setv(21, 20, 20, 1, 40, 30, 0, D, 1 - D);
    setv(22, 20, 20, 1, 40, 20, 0, 0, 1 - D);
    setv(23, 20, 20, 1, 40, 20, 0, 0, 1 - D);
    setv(24, 20, 20, 1, 40, 20, 0, 0, 1 - D);
    setv(25, 20, 20, 1, 40, 20, 0, 0, 1);

    // Reset held while clk_in toggles
    @(posedge clk80); #1;
    repeat (3) begin hold(1'b1, 7); hold(1'b0, 7); end
    chk_zero("rst_held");
    reset = 1'b1;
    hold(1'b0, 5);

    for (int i = 0; i < NV; i++) begin
      mark();
      hold(1'b1, tbl[i].hi);
      hold(1'b0, tbl[i].lo);
      chk($sformatf("v%0d_meas_cnt", i), n_meas - b_meas, tbl[i].meas);
      if (tbl[i].meas != 0) begin
        chk($sformatf("v%0d_period", i), last_per, tbl[i].period);
        chk($sformatf("v%0d_high", i), last_high, tbl[i].high);
      end
      chk($sformatf("v%0d_err_period", i), n_err - b_err, tbl[i].err);
      chk($sformatf("v%0d_err_duty", i), n_duty - b_duty, tbl[i].duty);
      chk($sformatf("v%0d_locked", i), int'(locked), tbl[i].lock);
      chk($sformatf("v%0d_stalled", i), int'(stalled), 0);
    end

    // Stall: clk_in held high for 250 cycles; rise is acted on at the 3rd edge
    mark();
    clk_in = 1'b1;
    repeat (3) @(posedge clk80);
    repeat (TIMEOUT - 1) @(posedge clk80);
    #1;
    chk("stall_pre_stalled", int'(stalled), 0);
    chk("stall_pre_locked", int'(locked), 1);
    @(posedge clk80); #1;
    chk("stall_stalled", int'(stalled), 1);
    chk("stall_locked", int'(locked), 0);
    chk("stall_meas_cnt", n_meas - b_meas, 1);
    chk("stall_last_period", last_per, 40);
    chk("stall_no_err", n_err - b_err, 0);
    hold(1'b1, 250 - 3 - TIMEOUT);
    hold(1'b0, 20);
    chk("stall_hold", int'(stalled), 1);
    clk_in = 1'b1;
    repeat (2) @(posedge clk80); #1;
    chk("stall_before_rise", int'(stalled), 1);
    @(posedge clk80); #1;
    chk("stall_cleared", int'(stalled), 0);
    mark();
    hold(1'b1, 17);
    hold(1'b0, 20);
    hold(1'b1, 5);
    chk("post_stall_meas_cnt", n_meas - b_meas, 1);
    chk("post_stall_period", last_per, 40);
    chk("post_stall_high", last_high, 20);
    chk("post_stall_locked", int'(locked), 0);

    // Reset pulsed mid-LOW
    hold(1'b0, 10);
    reset = 1'b0;
    #1;
    chk_zero("rst_mid_low");
    repeat (3) @(posedge clk80); #1;
    reset = 1'b1;
    mark();
    hold(1'b0, 10);
    hold(1'b1, 20);
    hold(1'b0, 20);
    chk("rst_no_early_meas", n_meas - b_meas, 0);
    hold(1'b1, 5);
    chk("rst_first_meas", n_meas - b_meas, 1);
    chk("rst_first_period", last_per, 40);
    chk("rst_first_high", last_high, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
